// File: rtl/riscv_hazard_pkg.sv
// Shared types for the EX-stage hazard/forwarding controller.
// Covers forward select encodings, FSM states and in-flight stage records.
package riscv_hazard_pkg;

  localparam int REG_ADDR_BITS = 5;
  localparam int STAGES        = 3;  // EX, MEM, WB

  typedef enum logic [1:0] {
    FWD_REGFILE   = 2'b00,
    FWD_WB_MUX    = 2'b01,
    FWD_EXMEM_REG = 2'b10,
    FWD_ALT       = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } hazard_state_t;

  typedef struct packed {
    logic                     valid;
    logic [REG_ADDR_BITS-1:0] rd;
    logic                     reg_write;
    logic                     is_load;
  } stage_rec_t;

  // x0 is hardwired, so a write to it never produces a forwardable value
  function automatic logic is_producer(input stage_rec_t r);
    return r.valid & r.reg_write & (r.rd != '0);
  endfunction

  // Nearer stage (EX) wins because it holds the younger write to the register
  function automatic fwd_sel_t src_fwd(input stage_rec_t ex, input stage_rec_t mem,
                                       input logic use_src,
                                       input logic [REG_ADDR_BITS-1:0] rs);
    if (use_src && is_producer(ex) && (ex.rd == rs))
      return FWD_EXMEM_REG;
    else if (use_src && is_producer(mem) && (mem.rd == rs))
      return FWD_WB_MUX;
    else
      return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/hazard_stage_tracker.sv
// One in-flight stage record: clear beats load, otherwise the record holds.
// Only the valid bit is reset; the payload is meaningless while invalid.
module hazard_stage_tracker
  import riscv_hazard_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       load,
  input  logic       clear,
  input  stage_rec_t rec_d,
  output stage_rec_t rec_q
);

  logic                     valid_p1;
  logic [REG_ADDR_BITS-1:0] rd_p1;
  logic                     reg_write_p1;
  logic                     is_load_p1;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)
      valid_p1 <= 1'b0;
    else if (clear)
      valid_p1 <= 1'b0;
    else if (load)
      valid_p1 <= rec_d.valid;
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      rd_p1        <= rec_d.rd;
      reg_write_p1 <= rec_d.reg_write;
      is_load_p1   <= rec_d.is_load;
    end
  end

  assign rec_q = '{valid: valid_p1, rd: rd_p1, reg_write: reg_write_p1, is_load: is_load_p1};

endmodule

// File: rtl/hazard_forward_controller.sv
// Tracks EX/MEM/WB destination registers, registers ALU/store forward selects
// for the instruction entering EX, and sequences the one-cycle load-use stall.
module hazard_forward_controller
  import riscv_hazard_pkg::*;
#(
  parameter int reg_addr_bits = REG_ADDR_BITS
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     id_valid,
  input  logic [reg_addr_bits-1:0] id_rs1,
  input  logic [reg_addr_bits-1:0] id_rs2,
  input  logic [reg_addr_bits-1:0] id_rd,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic                     id_reg_write,
  input  logic                     id_is_load,
  input  logic                     id_alu_src_imm,
  input  logic                     id_zero_a,
  input  logic                     flush,
  input  logic                     freeze,
  output logic [1:0]               forward_controller_1,
  output logic [1:0]               forward_controller_2,
  output logic [1:0]               store_data_sel,
  output logic                     pc_write,
  output logic                     ifid_write,
  output logic                     idex_bubble
);

  stage_rec_t    recs [STAGES];
  stage_rec_t    id_rec_p0;
  hazard_state_t state_q, state_d;
  logic          hazard, stall, kill_ex;
  fwd_sel_t      rs1_sel, rs2_sel;
  fwd_sel_t      fwd1_p1, fwd2_p1, sd_p1;

  assign id_rec_p0 = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};

  assign hazard = id_valid && is_producer(recs[0]) && recs[0].is_load &&
                  ((id_use_rs1 && (id_rs1 == recs[0].rd)) ||
                   (id_use_rs2 && (id_rs2 == recs[0].rd)));

  // Once stalled the load has moved to MEM, so the hazard is never re-raised
  assign stall   = (state_q == RUN) && hazard && !flush && !freeze;
  assign kill_ex = flush || stall;

  assign rs1_sel = src_fwd(recs[0], recs[1], id_use_rs1, id_rs1);
  assign rs2_sel = src_fwd(recs[0], recs[1], id_use_rs2, id_rs2);

  // ---- ID -> EX -> MEM -> WB record pipeline ----
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_ex
      hazard_stage_tracker u_trk (
        .CLK   (CLK),
        .RST_n (RST_n),
        .load  (!freeze),
        .clear (!freeze && kill_ex),
        .rec_d (id_rec_p0),
        .rec_q (recs[g])
      );
    end else begin : g_later
      hazard_stage_tracker u_trk (
        .CLK   (CLK),
        .RST_n (RST_n),
        .load  (!freeze),
        .clear (1'b0),
        .rec_d (recs[g-1]),
        .rec_q (recs[g])
      );
    end
  end

  // ---- EX-stage operand selects, captured at the advance edge ----
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      fwd1_p1 <= FWD_REGFILE;
      fwd2_p1 <= FWD_REGFILE;
      sd_p1   <= FWD_REGFILE;
    end else if (!freeze) begin
      if (kill_ex) begin
        fwd1_p1 <= FWD_REGFILE;
        fwd2_p1 <= FWD_REGFILE;
        sd_p1   <= FWD_REGFILE;
      end else begin
        fwd1_p1 <= id_zero_a      ? FWD_ALT : rs1_sel;
        fwd2_p1 <= id_alu_src_imm ? FWD_ALT : rs2_sel;
        sd_p1   <= rs2_sel;
      end
    end
  end

  assign forward_controller_1 = fwd1_p1;
  assign forward_controller_2 = fwd2_p1;
  assign store_data_sel       = sd_p1;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      state_d = RUN;
      if (flush) begin
        idex_bubble = 1'b1;
      end else if (stall) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        state_d     = LOAD_STALL;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_controller.sv
// Directed bench for hazard_forward_controller: forwarding, load-use stall,
// flush/freeze interaction and asynchronous reset, checked with immediate asserts.
module tb_hazard_forward_controller;
  import riscv_hazard_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
  logic       id_alu_src_imm, id_zero_a, flush, freeze;
  logic [1:0] forward_controller_1, forward_controller_2, store_data_sel;
  logic       pc_write, ifid_write, idex_bubble;

  int n_cmp  = 0;
  int n_fail = 0;

  hazard_forward_controller dut (
    .CLK                  (CLK),
    .RST_n                (RST_n),
    .id_valid             (id_valid),
    .id_rs1               (id_rs1),
    .id_rs2               (id_rs2),
    .id_rd                (id_rd),
    .id_use_rs1           (id_use_rs1),
    .id_use_rs2           (id_use_rs2),
    .id_reg_write         (id_reg_write),
    .id_is_load           (id_is_load),
    .id_alu_src_imm       (id_alu_src_imm),
    .id_zero_a            (id_zero_a),
    .flush                (flush),
    .freeze               (freeze),
    .forward_controller_1 (forward_controller_1),
    .forward_controller_2 (forward_controller_2),
    .store_data_sel       (store_data_sel),
    .pc_write             (pc_write),
    .ifid_write           (ifid_write),
    .idex_bubble          (idex_bubble)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic rw, input logic ld, input logic imm, input logic za);
    id_valid       = v;
    id_rs1         = rs1;
    id_rs2         = rs2;
    id_rd          = rd;
    id_use_rs1     = u1;
    id_use_rs2     = u2;
    id_reg_write   = rw;
    id_is_load     = ld;
    id_alu_src_imm = imm;
    id_zero_a      = za;
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic pc, input logic ifid, input logic bub);
    chk({tag, "_pc_write"},    {1'b0, pc_write},    {1'b0, pc});
    chk({tag, "_ifid_write"},  {1'b0, ifid_write},  {1'b0, ifid});
    chk({tag, "_idex_bubble"}, {1'b0, idex_bubble}, {1'b0, bub});
  endtask

  task automatic chk_sel(input string tag, input logic [1:0] f1, input logic [1:0] f2,
                         input logic [1:0] sd);
    chk({tag, "_fc1"}, forward_controller_1, f1);
    chk({tag, "_fc2"}, forward_controller_2, f2);
    chk({tag, "_sd"},  store_data_sel,       sd);
  endtask

  initial begin
    RST_n  = 1'b0;
    flush  = 1'b0;
    freeze = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_sel("reset", 2'b00, 2'b00, 2'b00);
    chk_ctl("reset", 1, 1, 0);
    chk("reset_state", {1'b0, dut.state_q}, 2'b00);
    @(negedge CLK);
    RST_n = 1'b1;
    tick();

    // addi x5 ; add x6,x5,x1 back-to-back
    issue(1, 1, 0, 5, 1, 0, 1, 0, 1, 0);
    tick();
    issue(1, 5, 1, 6, 1, 1, 1, 0, 0, 0);
    chk_ctl("ex_fwd_nostall", 1, 1, 0);
    tick();
    chk_sel("ex_fwd", 2'b10, 2'b00, 2'b00);

    // addi x5 ; nop ; sub x7,x1,x5
    issue(1, 1, 0, 5, 1, 0, 1, 0, 1, 0);
    tick();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    issue(1, 1, 5, 7, 1, 1, 1, 0, 0, 0);
    tick();
    chk_sel("mem_fwd", 2'b00, 2'b01, 2'b01);

    // same with producer rd = x0
    issue(1, 1, 0, 0, 1, 0, 1, 0, 1, 0);
    tick();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    issue(1, 1, 0, 7, 1, 1, 1, 0, 0, 0);
    tick();
    chk_sel("x0_nofwd", 2'b00, 2'b00, 2'b00);

    // lw x8 ; add x9,x8,x8
    issue(1, 2, 0, 8, 1, 0, 1, 1, 1, 0);
    chk_ctl("lw_issue", 1, 1, 0);
    tick();
    issue(1, 8, 8, 9, 1, 1, 1, 0, 0, 0);
    chk_ctl("lu_stall", 0, 0, 1);
    tick();
    chk_sel("lu_bubble", 2'b00, 2'b00, 2'b00);
    chk("lu_state", {1'b0, dut.state_q}, 2'b01);
    chk_ctl("lu_no_restall", 1, 1, 0);
    tick();
    chk_sel("lu_fwd", 2'b01, 2'b01, 2'b01);
    chk("lu_state_run", {1'b0, dut.state_q}, 2'b00);

    // lw x8 ; addi x3,x8,4
    issue(1, 2, 0, 8, 1, 0, 1, 1, 1, 0);
    tick();
    issue(1, 8, 0, 3, 1, 0, 1, 0, 1, 0);
    chk_ctl("lu_addi_stall", 0, 0, 1);
    tick();
    tick();
    chk_sel("lu_addi", 2'b01, 2'b11, 2'b00);

    // lw x8 ; sw x8,0(x2)
    issue(1, 2, 0, 8, 1, 0, 1, 1, 1, 0);
    tick();
    issue(1, 2, 8, 0, 1, 1, 0, 0, 1, 0);
    chk_ctl("lu_sw_stall", 0, 0, 1);
    tick();
    tick();
    chk_sel("lu_sw", 2'b00, 2'b11, 2'b01);

    // hazard coincident with flush
    issue(1, 2, 0, 8, 1, 0, 1, 1, 1, 0);
    tick();
    flush = 1'b1;
    issue(1, 8, 8, 9, 1, 1, 1, 0, 0, 0);
    chk_ctl("flush_hazard", 1, 1, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_state", {1'b0, dut.state_q}, 2'b00);
    chk_sel("flush_sel", 2'b00, 2'b00, 2'b00);

    // freeze held three cycles during LOAD_STALL
    issue(1, 2, 0, 8, 1, 0, 1, 1, 1, 0);
    tick();
    issue(1, 8, 8, 9, 1, 1, 1, 0, 0, 0);
    tick();
    freeze = 1'b1;
    #1;
    chk_ctl("freeze", 0, 0, 0);
    tick();
    tick();
    tick();
    chk("freeze_state", {1'b0, dut.state_q}, 2'b01);
    chk_sel("freeze_sel", 2'b00, 2'b00, 2'b00);
    chk_ctl("freeze_held", 0, 0, 0);
    freeze = 1'b0;
    #1;
    chk_ctl("unfreeze", 1, 1, 0);
    tick();
    chk_sel("unfreeze_fwd", 2'b01, 2'b01, 2'b01);
    chk("unfreeze_state", {1'b0, dut.state_q}, 2'b00);

    // reset asserted mid-stall
    issue(1, 2, 0, 8, 1, 0, 1, 1, 1, 0);
    tick();
    issue(1, 8, 8, 9, 1, 1, 1, 0, 0, 0);
    tick();
    chk("pre_rst_state", {1'b0, dut.state_q}, 2'b01);
    RST_n = 1'b0;
    #1;
    chk("rst_state", {1'b0, dut.state_q}, 2'b00);
    chk_sel("rst_sel", 2'b00, 2'b00, 2'b00);
    chk_ctl("rst_ctl", 1, 1, 0);
    RST_n = 1'b1;

    // lui x4
    issue(1, 0, 0, 4, 0, 0, 1, 0, 1, 1);
    chk_ctl("lui_issue", 1, 1, 0);
    tick();
    chk_sel("lui", 2'b11, 2'b11, 2'b00);
    RST_n = 1'b0;
    #1;
    chk_sel("lui_rst", 2'b00, 2'b00, 2'b00);
    RST_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
